led_ctrl: RTL and testbench

//   Parametrised DIP-switch-to-LED controller: successor to the plain

---
 rtl/led_ctrl.sv | 144 ++++++++++++++
 tb/tb_led_ctrl.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_ctrl.sv
// Debounced DIP switches driving LEDs in pass/blink/chase/count modes.
// Optional LED_PWM_EN adds a duty input that dims the LED outputs.
module led_ctrl #(
  parameter int WIDTH    = 8,
  parameter int DEB_CNT  = 1000,
  parameter int TICK_DIV = 25000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] dip,
  input  logic [1:0]       mode,
`ifdef LED_PWM_EN
  input  logic [3:0]       duty,
`endif
  output logic [WIDTH-1:0] led,
  output logic [WIDTH-1:0] dip_db,
  output logic             tick
);

  localparam int CW = $clog2(DEB_CNT);
  localparam int PW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] DEB_MAX = CW'(DEB_CNT - 1);
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  typedef enum logic [1:0] {
    M_PASS  = 2'b00,
    M_BLINK = 2'b01,
    M_CHASE = 2'b10,
    M_COUNT = 2'b11
  } mode_t;

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;
  logic [CW-1:0]    cnt [WIDTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      s1     <= '0;
      s2     <= '0;
      dip_db <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      s1 <= dip;
      s2 <= s1;
      for (int i = 0; i < WIDTH; i++) begin
        if (s2[i] == dip_db[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == DEB_MAX) begin
          dip_db[i] <= s2[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  mode_t            mode_q;
  mode_t            mode_d;
  logic             chg;
  logic             tick_c;
  logic [PW-1:0]    presc;
  logic [PW-1:0]    presc_d;
  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] count_d;
  logic [WIDTH-1:0] pattern;
  logic [WIDTH-1:0] pat_d;
  logic             phase;
  logic             phase_d;
  logic [WIDTH-1:0] led_reg;
  logic [WIDTH-1:0] led_d;

  always_comb begin
    mode_d  = mode_t'(mode);
    chg     = (mode_d != mode_q);
    tick_c  = (presc == PRE_MAX) && !chg;
    presc_d = (presc == PRE_MAX) ? '0 : presc + PW'(1);
    count_d = count;
    pat_d   = pattern;
    phase_d = phase;
    led_d   = '0;
    // a mode switch restarts the animation from a known frame
    if (chg) begin
      presc_d = '0;
      count_d = '0;
      pat_d   = ONE;
      phase_d = 1'b1;
    end else if (tick_c) begin
      phase_d = !phase;
      count_d = count + ONE;
      if (dip_db[0]) begin
        pat_d = {pattern[0], pattern[WIDTH-1:1]};
      end else begin
        pat_d = {pattern[WIDTH-2:0], pattern[WIDTH-1]};
      end
    end
    unique case (mode_q)
      M_PASS:  led_d = dip_db;
      M_BLINK: led_d = phase ? dip_db : '0;
      M_CHASE: led_d = pattern;
      M_COUNT: led_d = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q  <= M_PASS;
      presc   <= '0;
      count   <= '0;
      pattern <= ONE;
      phase   <= 1'b0;
      led_reg <= '0;
    end else begin
      mode_q  <= mode_d;
      presc   <= presc_d;
      count   <= count_d;
      pattern <= pat_d;
      phase   <= phase_d;
      led_reg <= led_d;
    end
  end

  assign tick = tick_c & ~rst;

`ifdef LED_PWM_EN
  logic [3:0] pwm_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_cnt <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + 4'd1;
    end
  end

  assign led = led_reg & {WIDTH{pwm_cnt < duty}};
`else
  assign led = led_reg;
`endif

endmodule

// File: tb/tb_led_ctrl.sv
// Directed self-checking bench for led_ctrl (WIDTH=8, DEB_CNT=4, TICK_DIV=8).
// Define LED_PWM_EN for both files to exercise the dimming path.
module tb_led_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] dip;
  logic [1:0] mode;
  logic [7:0] led;
  logic [7:0] dip_db;
  logic       tick;
  int         checks   = 0;
  int         failures = 0;

`ifdef LED_PWM_EN
  logic [3:0] duty = 4'd15;
  logic [3:0] pc;
`endif

  always #5 clk = ~clk;

  led_ctrl #(
    .WIDTH    (8),
    .DEB_CNT  (4),
    .TICK_DIV (8)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .dip    (dip),
    .mode   (mode),
`ifdef LED_PWM_EN
    .duty   (duty),
`endif
    .led    (led),
    .dip_db (dip_db),
    .tick   (tick)
  );

`ifdef LED_PWM_EN
  // independent model of the free-running dimming phase
  always @(posedge clk) pc <= rst ? 4'd0 : pc + 4'd1;

  function automatic logic [7:0] gate(input logic [7:0] v);
    return (pc < duty) ? v : 8'h00;
  endfunction
`else
  function automatic logic [7:0] gate(input logic [7:0] v);
    return v;
  endfunction
`endif

  function automatic logic [7:0] rotl(input logic [7:0] v, input int k);
    logic [7:0] r;
    r = v;
    for (int i = 0; i < k; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  function automatic logic [7:0] rotr(input logic [7:0] v, input int k);
    logic [7:0] r;
    r = v;
    for (int i = 0; i < k; i++) r = {r[0], r[7:1]};
    return r;
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst  = 1'b1;
    dip  = 8'h00;
    mode = 2'b00;
    step(2);
    checks++;
    if (led !== 8'h00) begin
      failures++;
      $display("FAIL reset_led got=%h exp=00", led);
    end
    checks++;
    if (dip_db !== 8'h00) begin
      failures++;
      $display("FAIL reset_dip_db got=%h exp=00", dip_db);
    end
    checks++;
    if (tick !== 1'b0) begin
      failures++;
      $display("FAIL reset_tick got=%b exp=0", tick);
    end
    rst = 1'b0;
  endtask

  task automatic test_pass;
    dip = 8'hA5;
    step(5);
    checks++;
    if (dip_db !== 8'h00) begin
      failures++;
      $display("FAIL pass_early got=%h exp=00", dip_db);
    end
    step(1);
    checks++;
    if (dip_db !== 8'hA5) begin
      failures++;
      $display("FAIL pass_dip_db got=%h exp=a5", dip_db);
    end
    checks++;
    if (led !== 8'h00) begin
      failures++;
      $display("FAIL pass_led_lag got=%h exp=00", led);
    end
    step(1);
    checks++;
    if (led !== gate(8'hA5)) begin
      failures++;
      $display("FAIL pass_led got=%h exp=%h", led, gate(8'hA5));
    end
  endtask

  task automatic test_glitch;
    dip = 8'h00;
    step(10);
    dip = 8'h01;
    step(3);
    dip = 8'h00;
    for (int i = 0; i < 10; i++) begin
      step(1);
      checks++;
      if (dip_db !== 8'h00 || led !== 8'h00) begin
        failures++;
        $display("FAIL glitch3 dip_db=%h led=%h exp=00", dip_db, led);
      end
    end
    dip = 8'h01;
    step(4);
    dip = 8'h00;
    step(2);
    checks++;
    if (dip_db !== 8'h01) begin
      failures++;
      $display("FAIL pulse4 got=%h exp=01", dip_db);
    end
    step(10);
    checks++;
    if (dip_db !== 8'h00) begin
      failures++;
      $display("FAIL pulse4_back got=%h exp=00", dip_db);
    end
  endtask

  task automatic test_chase;
    mode = 2'b10;
    step(2);
    checks++;
    if (led !== gate(8'h01)) begin
      failures++;
      $display("FAIL chase_start got=%h exp=%h", led, gate(8'h01));
    end
    step(5);
    checks++;
    if (tick !== 1'b0) begin
      failures++;
      $display("FAIL chase_tick_early got=%b exp=0", tick);
    end
    step(1);
    checks++;
    if (tick !== 1'b1) begin
      failures++;
      $display("FAIL chase_tick got=%b exp=1", tick);
    end
    step(1);
    checks++;
    if (tick !== 1'b0 || led !== gate(8'h01)) begin
      failures++;
      $display("FAIL chase_hold tick=%b led=%h exp=0/%h", tick, led,
               gate(8'h01));
    end
    for (int k = 1; k <= 8; k++) begin
      step(k == 1 ? 1 : 8);
      checks++;
      if (led !== gate(rotl(8'h01, k))) begin
        failures++;
        $display("FAIL chase_left k=%0d got=%h exp=%h", k, led,
                 gate(rotl(8'h01, k)));
      end
    end
    mode = 2'b00;
    dip  = 8'h01;
    step(10);
    checks++;
    if (led !== gate(8'h01)) begin
      failures++;
      $display("FAIL chase_dir_pass got=%h exp=%h", led, gate(8'h01));
    end
    mode = 2'b10;
    step(2);
    checks++;
    if (led !== gate(8'h01)) begin
      failures++;
      $display("FAIL chase_restart got=%h exp=%h", led, gate(8'h01));
    end
    for (int k = 1; k <= 8; k++) begin
      step(8);
      checks++;
      if (led !== gate(rotr(8'h01, k))) begin
        failures++;
        $display("FAIL chase_right k=%0d got=%h exp=%h", k, led,
                 gate(rotr(8'h01, k)));
      end
    end
  endtask

  task automatic test_count;
    mode = 2'b11;
    step(2);
    checks++;
    if (led !== 8'h00) begin
      failures++;
      $display("FAIL count_start got=%h exp=00", led);
    end
    for (int k = 1; k <= 2; k++) begin
      step(8);
      checks++;
      if (led !== gate(8'(k))) begin
        failures++;
        $display("FAIL count_inc k=%0d got=%h exp=%h", k, led, gate(8'(k)));
      end
    end
    step(8 * 253);
    checks++;
    if (led !== gate(8'hFF)) begin
      failures++;
      $display("FAIL count_ff got=%h exp=%h", led, gate(8'hFF));
    end
    step(8);
    checks++;
    if (led !== 8'h00) begin
      failures++;
      $display("FAIL count_wrap got=%h exp=00", led);
    end
    step(8 * 3 + 3);
    checks++;
    if (led !== gate(8'h03)) begin
      failures++;
      $display("FAIL count_pre_rst got=%h exp=%h", led, gate(8'h03));
    end
    rst = 1'b1;
    step(1);
    checks++;
    if (led !== 8'h00 || dip_db !== 8'h00) begin
      failures++;
      $display("FAIL count_rst led=%h dip_db=%h exp=00", led, dip_db);
    end
    rst = 1'b0;
  endtask

  task automatic test_blink;
    dip  = 8'h3C;
    mode = 2'b00;
    step(10);
    checks++;
    if (led !== gate(8'h3C)) begin
      failures++;
      $display("FAIL blink_pre got=%h exp=%h", led, gate(8'h3C));
    end
    mode = 2'b01;
    step(2);
    checks++;
    if (led !== gate(8'h3C)) begin
      failures++;
      $display("FAIL blink_entry got=%h exp=%h", led, gate(8'h3C));
    end
    step(7);
    checks++;
    if (led !== gate(8'h3C)) begin
      failures++;
      $display("FAIL blink_hold got=%h exp=%h", led, gate(8'h3C));
    end
    step(1);
    checks++;
    if (led !== 8'h00) begin
      failures++;
      $display("FAIL blink_off got=%h exp=00", led);
    end
    step(8);
    checks++;
    if (led !== gate(8'h3C)) begin
      failures++;
      $display("FAIL blink_on got=%h exp=%h", led, gate(8'h3C));
    end
    step(8);
    checks++;
    if (led !== 8'h00) begin
      failures++;
      $display("FAIL blink_off2 got=%h exp=00", led);
    end
  endtask

`ifdef LED_PWM_EN
  task automatic test_pwm;
    int on;
    mode = 2'b00;
    dip  = 8'hFF;
    step(10);
    duty = 4'd4;
    on   = 0;
    for (int i = 0; i < 16; i++) begin
      step(1);
      if (led === 8'hFF) on++;
    end
    checks++;
    if (on != 4) begin
      failures++;
      $display("FAIL pwm_duty4 on=%0d exp=4", on);
    end
    duty = 4'd0;
    on   = 0;
    for (int i = 0; i < 16; i++) begin
      step(1);
      if (led !== 8'h00) on++;
    end
    checks++;
    if (on != 0) begin
      failures++;
      $display("FAIL pwm_duty0 on=%0d exp=0", on);
    end
    duty = 4'd15;
  endtask
`endif

  initial begin
    test_reset();
    test_pass();
    test_glitch();
    test_chase();
    test_count();
    test_blink();
`ifdef LED_PWM_EN
    test_pwm();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
